// File: rtl/clock_pkg.sv
// Shared mode encodings, field limits and wrap helpers for the alarm clock.
package clock_pkg;
  localparam int FIELD_W = 6;
  localparam logic [FIELD_W-1:0] SEC_MAX = 6'd59;
  localparam logic [FIELD_W-1:0] MIN_MAX = 6'd59;

  typedef enum logic [2:0] {
    RUN    = 3'd0,
    SET_H  = 3'd1,
    SET_M  = 3'd2,
    SET_S  = 3'd3,
    SET_AH = 3'd4,
    SET_AM = 3'd5
  } mode_t;

  function automatic mode_t next_mode(input mode_t m);
    case (m)
      RUN:     next_mode = SET_H;
      SET_H:   next_mode = SET_M;
      SET_M:   next_mode = SET_S;
      SET_S:   next_mode = SET_AH;
      SET_AH:  next_mode = SET_AM;
      default: next_mode = RUN;
    endcase
  endfunction

  // One step up or down with wrap between 0 and max, no carry out.
  function automatic logic [FIELD_W-1:0] step_wrap(input logic [FIELD_W-1:0] v,
                                                   input logic [FIELD_W-1:0] max,
                                                   input logic up);
    if (up) step_wrap = (v == max) ? '0 : v + 1'b1;
    else    step_wrap = (v == '0) ? max : v - 1'b1;
  endfunction
endpackage

// File: rtl/clock_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV cycles while enabled.
// Counter is held at 0 whenever disabled, so re-enabling restarts a full period.
module clock_prescaler #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || !en)      cnt <= '0;
    else if (cnt == LAST) cnt <= '0;
    else                 cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/clock_alarm.sv
// Time-of-day clock with key-driven set modes and an auto-stopping alarm.
// Time fields update the cycle after a prescaler tick; key actions take effect on the rising-edge cycle.
module clock_alarm
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int RING_SEC = 60,
  parameter int HOUR_MAX = 23
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key,
  output logic [5:0] hour,
  output logic [5:0] minu,
  output logic [5:0] seco,
  output logic       hour_vld,
  output logic       minu_vld,
  output logic       seco_vld,
  output logic [5:0] al_hour,
  output logic [5:0] al_minu,
  output logic       al_en,
  output logic       ring,
  output logic [2:0] mode
);
  localparam logic [FIELD_W-1:0] H_MAX = FIELD_W'(HOUR_MAX);
  localparam int RC_W = $clog2(RING_SEC + 1);
  localparam logic [RC_W-1:0] RING_LAST = RC_W'(RING_SEC - 1);

  mode_t            st;
  logic [3:0]       key_q;
  logic [3:0]       kedge;
  logic             tick;
  logic [RC_W-1:0]  ring_cnt;
  logic             carry_m, carry_h, match;
  logic [5:0]       seco_n, minu_n, hour_n;

  assign mode  = st;
  assign kedge = key & ~key_q;

  clock_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (st == RUN),
    .tick (tick)
  );

  // Time as it will be after the pending tick, used for both update and alarm match.
  assign carry_m = (seco == SEC_MAX);
  assign carry_h = carry_m && (minu == MIN_MAX);
  assign seco_n  = step_wrap(seco, SEC_MAX, 1'b1);
  assign minu_n  = carry_m ? step_wrap(minu, MIN_MAX, 1'b1) : minu;
  assign hour_n  = carry_h ? step_wrap(hour, H_MAX, 1'b1) : hour;
  assign match   = al_en && (hour_n == al_hour) && (minu_n == al_minu) && (seco_n == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= RUN;
      key_q    <= '0;
      hour     <= '0;
      minu     <= '0;
      seco     <= '0;
      hour_vld <= 1'b0;
      minu_vld <= 1'b0;
      seco_vld <= 1'b0;
      al_hour  <= '0;
      al_minu  <= '0;
      al_en    <= 1'b0;
      ring     <= 1'b0;
      ring_cnt <= '0;
    end else begin
      key_q    <= key;
      hour_vld <= 1'b0;
      minu_vld <= 1'b0;
      seco_vld <= 1'b0;

      if (tick) begin
        seco     <= seco_n;
        seco_vld <= 1'b1;
        if (carry_m) begin
          minu     <= minu_n;
          minu_vld <= 1'b1;
        end
        if (carry_h) begin
          hour     <= hour_n;
          hour_vld <= 1'b1;
        end
        if (match) begin
          ring     <= 1'b1;
          ring_cnt <= '0;
        end else if (ring) begin
          if (ring_cnt == RING_LAST) ring <= 1'b0;
          else                       ring_cnt <= ring_cnt + 1'b1;
        end
      end

      // Only the highest-priority key edge of the cycle is acted on.
      if (kedge[0]) begin
        st   <= next_mode(st);
        ring <= 1'b0;
      end else if (kedge[3]) begin
        if (ring) begin
          ring <= 1'b0;
        end else begin
          al_en <= ~al_en;
          if (al_en) ring <= 1'b0;
        end
      end else if ((kedge[1] || kedge[2]) && st != RUN) begin
        case (st)
          SET_H: begin
            hour     <= step_wrap(hour, H_MAX, kedge[1]);
            hour_vld <= 1'b1;
          end
          SET_M: begin
            minu     <= step_wrap(minu, MIN_MAX, kedge[1]);
            minu_vld <= 1'b1;
          end
          SET_S: begin
            seco     <= step_wrap(seco, SEC_MAX, kedge[1]);
            seco_vld <= 1'b1;
          end
          SET_AH:  al_hour <= step_wrap(al_hour, H_MAX, kedge[1]);
          SET_AM:  al_minu <= step_wrap(al_minu, MIN_MAX, kedge[1]);
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_clock_alarm.sv
// Directed bench for clock_alarm; a scoreboard queue predicts every vld pulse.
module tb_clock_alarm;
  localparam int TD = 10;
  localparam int RS = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] key;
  logic [5:0] hour, minu, seco, al_hour, al_minu;
  logic       hour_vld, minu_vld, seco_vld, al_en, ring;
  logic [2:0] mode;

  always #5 clk = ~clk;

  clock_alarm #(.TICK_DIV(TD), .RING_SEC(RS), .HOUR_MAX(23)) dut (
    .clk(clk), .rst(rst), .key(key),
    .hour(hour), .minu(minu), .seco(seco),
    .hour_vld(hour_vld), .minu_vld(minu_vld), .seco_vld(seco_vld),
    .al_hour(al_hour), .al_minu(al_minu), .al_en(al_en), .ring(ring), .mode(mode)
  );

  int passes = 0;
  int total  = 0;
  int m_h = 0, m_m = 0, m_s = 0;
  logic [20:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the edge on which the key edge is acted on.
  task automatic press(input logic [3:0] k);
    key = 4'b0000;
    step(1);
    key = k;
    step(1);
  endtask

  function automatic logic [20:0] pack(input logic [2:0] v);
    return {v, 6'(m_h), 6'(m_m), 6'(m_s)};
  endfunction

  task automatic push_tick(input int n);
    logic [2:0] v;
    for (int i = 0; i < n; i++) begin
      v = {(m_s == 59 && m_m == 59), (m_s == 59), 1'b1};
      m_s = (m_s + 1) % 60;
      if (v[1]) m_m = (m_m + 1) % 60;
      if (v[2]) m_h = (m_h + 1) % 24;
      exp_q.push_back(pack(v));
    end
  endtask

  task automatic push_edit(input int f, input int d);
    logic [2:0] v;
    v = 3'b000;
    case (f)
      0: begin m_h = (m_h + d + 24) % 24; v = 3'b100; end
      1: begin m_m = (m_m + d + 60) % 60; v = 3'b010; end
      default: begin m_s = (m_s + d + 60) % 60; v = 3'b001; end
    endcase
    exp_q.push_back(pack(v));
  endtask

  always @(negedge clk) begin
    if (hour_vld || minu_vld || seco_vld) begin
      if (exp_q.size() == 0) chk("sb_unexpected_pulse", {hour_vld, minu_vld, seco_vld}, 0);
      else chk("sb_time", {hour_vld, minu_vld, seco_vld, hour, minu, seco}, exp_q.pop_front());
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_time"}, {hour, minu, seco}, 0);
    chk({tag, "_vld"}, {hour_vld, minu_vld, seco_vld}, 0);
    chk({tag, "_alarm"}, {al_hour, al_minu, al_en, ring}, 0);
    chk({tag, "_mode"}, mode, 0);
  endtask

  initial begin
    rst = 1'b1;
    key = 4'b0000;
    step(3);
    chk_reset("reset");

    // Free run for 60 ticks: seconds roll over into the first minute.
    rst = 1'b0;
    push_tick(60);
    for (int i = 0; i < 60; i++) begin
      step(10);
      chk("seco_vld_period", seco_vld, 1);
    end
    chk("run600_time", {hour, minu, seco}, {6'd0, 6'd1, 6'd0});

    // Edit to 23:59:59, including the minute wrap in both directions.
    press(4'b0001);
    chk("mode_set_h", mode, 1);
    push_edit(0, -1);
    press(4'b0100);
    chk("hour_dec_wrap", hour, 23);
    press(4'b0001);
    push_edit(1, -1);
    press(4'b0100);
    chk("minu_dec_to0", minu, 0);
    push_edit(1, -1);
    press(4'b0100);
    chk("minu_dec_wrap", {hour, minu, minu_vld}, {6'd23, 6'd59, 1'b1});
    step(1);
    chk("minu_vld_single", minu_vld, 0);
    push_edit(1, +1);
    press(4'b0010);
    chk("minu_inc_wrap", minu, 0);
    push_edit(1, -1);
    press(4'b0100);
    press(4'b0001);
    push_edit(2, -1);
    press(4'b0100);
    chk("seco_dec_wrap", seco, 59);
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    chk("mode_back_run", mode, 0);

    // First tick a full period after returning to RUN; full day wrap.
    push_tick(1);
    step(9);
    chk("no_early_tick", {hour_vld, minu_vld, seco_vld, seco}, {3'b000, 6'd59});
    step(1);
    chk("wrap_all_vld", {hour_vld, minu_vld, seco_vld}, 3'b111);
    chk("wrap_time", {hour, minu, seco}, 0);

    // Mode and inc together in RUN: mode wins, inc discarded.
    press(4'b0011);
    chk("prio_mode", {mode, hour, hour_vld}, {3'd1, 6'd0, 1'b0});

    // Alarm at 00:01, armed, then run to it.
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    press(4'b0010);
    chk("al_minu_set", {al_hour, al_minu}, {6'd0, 6'd1});
    press(4'b1000);
    chk("al_en_on", al_en, 1);
    press(4'b0001);
    push_tick(60);
    step(599);
    chk("ring_before_match", ring, 0);
    step(1);
    chk("ring_on_match", {ring, hour, minu, seco}, {1'b1, 6'd0, 6'd1, 6'd0});
    push_tick(3);
    step(10);
    chk("ring_tick1", ring, 1);
    step(10);
    chk("ring_tick2", ring, 1);
    step(10);
    chk("ring_auto_stop", {ring, al_en}, 2'b01);

    // Re-arm for 00:02 and dismiss while ringing.
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    press(4'b0010);
    press(4'b0001);
    push_tick(57);
    step(570);
    chk("ring_second", {ring, minu, seco}, {1'b1, 6'd2, 6'd0});
    press(4'b1000);
    chk("dismiss", {ring, al_en}, 2'b01);

    // Back up to 00:01:59, ring again, then leave RUN and reset mid-edit.
    press(4'b0001);
    press(4'b0001);
    push_edit(1, -1);
    press(4'b0100);
    press(4'b0001);
    push_edit(2, -1);
    press(4'b0100);
    chk("edit_no_ring", {ring, minu, seco}, {1'b0, 6'd1, 6'd59});
    press(4'b0001);
    press(4'b0001);
    press(4'b0001);
    push_tick(1);
    step(10);
    chk("ring_third", ring, 1);
    press(4'b0001);
    chk("ring_leave_run", {ring, mode}, {1'b0, 3'd1});
    press(4'b0001);
    press(4'b0001);
    push_edit(2, +1);
    press(4'b0010);
    chk("seco_inc_set_s", {mode, seco}, {3'd3, 6'd1});
    rst = 1'b1;
    key = 4'b0000;
    step(1);
    exp_q.delete();
    m_h = 0; m_m = 0; m_s = 0;
    chk_reset("mid_edit_reset");

    rst = 1'b0;
    push_tick(1);
    step(9);
    chk("post_reset_no_tick", seco_vld, 0);
    step(1);
    chk("post_reset_tick", {seco_vld, seco}, {1'b1, 6'd1});
    step(2);
    chk("sb_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
